// File: rtl/gpio_ctrl_pkg.sv
// Shared constants and types for the GPIO APB controller: register offsets,
// APB FSM state encoding and the default bank width.
package gpio_ctrl_pkg;

    localparam int unsigned GPIO_DEFAULT_WIDTH = 16;

    localparam logic [4:0] GPIO_DIR_OFS      = 5'h00;
    localparam logic [4:0] GPIO_DOUT_OFS     = 5'h04;
    localparam logic [4:0] GPIO_DIN_OFS      = 5'h08;
    localparam logic [4:0] GPIO_INT_EN_OFS   = 5'h0C;
    localparam logic [4:0] GPIO_INT_POL_OFS  = 5'h10;
    localparam logic [4:0] GPIO_INT_STAT_OFS = 5'h14;
    localparam logic [4:0] GPIO_INT_PEND_OFS = 5'h18;

    typedef enum logic {
        IDLE,
        ACCESS
    } apb_state_e;

endpackage

// File: rtl/gpio_apb_ctrl_if.sv
// APB3 bus bundle between a master and the GPIO controller.
interface gpio_apb_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 8
) ();

    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [31:0]           pwdata;
    logic [31:0]           prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/gpio_in_sync.sv
// Two-flop synchronizer for asynchronous pin inputs, plus a delayed copy of
// the synchronized value used for edge detection.
module gpio_in_sync #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] prev
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync = sync_q;
    assign prev = prev_q;

endmodule

// File: rtl/gpio_apb_ctrl.sv
// APB slave for one GPIO bank: direction/output registers, synchronized input
// sampling and per-pin edge interrupts folded into a single level interrupt.
module gpio_apb_ctrl
    import gpio_ctrl_pkg::*;
#(
    parameter int unsigned GPIO_DATA_WIDTH = GPIO_DEFAULT_WIDTH,
    parameter int unsigned ADDR_WIDTH      = 8
) (
    input  logic                       pclk,
    input  logic                       p_reset,
    gpio_apb_ctrl_if.slave             apb,
    output logic [GPIO_DATA_WIDTH-1:0] n_gpio_pin_oe,
    output logic [GPIO_DATA_WIDTH-1:0] gpio_pin_out,
    input  logic [GPIO_DATA_WIDTH-1:0] gpio_pin_in,
    output logic                       gpio_irq
);

    localparam int unsigned W = GPIO_DATA_WIDTH;

    apb_state_e      state_q;
    logic            pready_q;
    logic            pslverr_q;
    logic [31:0]     prdata_q;

    logic [W-1:0]    dir_q;
    logic [W-1:0]    dout_q;
    logic [W-1:0]    int_en_q;
    logic [W-1:0]    int_pol_q;
    logic [W-1:0]    int_stat_q;
    logic            irq_q;

    logic [W-1:0]    din_sync;
    logic [W-1:0]    din_prev;
    logic [W-1:0]    edge_evt;

    logic [ADDR_WIDTH-1:0] addr;
    logic [4:0]      ofs;
    logic            addr_err;
    logic            ro_reg;
    logic            acc_err;
    logic [31:0]     rdata;
    logic [W-1:0]    wdata;
    logic            commit;
    logic [W-1:0]    w1c_mask;
    logic            unused_pwdata;

    gpio_in_sync #(
        .WIDTH (W)
    ) u_in_sync (
        .clk  (pclk),
        .rst  (p_reset),
        .din  (gpio_pin_in),
        .sync (din_sync),
        .prev (din_prev)
    );

    assign addr          = apb.paddr;
    assign ofs           = addr[4:0];
    assign addr_err      = ((addr >> 5) != '0) || (ofs[1:0] != 2'b00) || (ofs >= 5'h1C);
    assign ro_reg        = (ofs == GPIO_DIN_OFS) || (ofs == GPIO_INT_PEND_OFS);
    assign acc_err       = addr_err || (apb.pwrite && ro_reg);
    assign wdata         = apb.pwdata[W-1:0];
    assign unused_pwdata = ^apb.pwdata;

    // Address and write data are held stable through the access phase, so the
    // error latched at setup gates the commit.
    assign commit   = (state_q == ACCESS) && apb.psel && pready_q && apb.pwrite && !pslverr_q;
    assign w1c_mask = (commit && ofs == GPIO_INT_STAT_OFS) ? wdata : '0;
    assign edge_evt = (int_pol_q & din_sync & ~din_prev) | (~int_pol_q & ~din_sync & din_prev);

    always_comb begin
        rdata = '0;
        case (ofs)
            GPIO_DIR_OFS:      rdata[W-1:0] = dir_q;
            GPIO_DOUT_OFS:     rdata[W-1:0] = dout_q;
            GPIO_DIN_OFS:      rdata[W-1:0] = din_sync;
            GPIO_INT_EN_OFS:   rdata[W-1:0] = int_en_q;
            GPIO_INT_POL_OFS:  rdata[W-1:0] = int_pol_q;
            GPIO_INT_STAT_OFS: rdata[W-1:0] = int_stat_q;
            GPIO_INT_PEND_OFS: rdata[W-1:0] = int_stat_q & int_en_q;
            default:           rdata        = '0;
        endcase
        if (addr_err) begin
            rdata = '0;
        end
    end

    always_ff @(posedge pclk) begin
        if (p_reset) begin
            state_q   <= IDLE;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (apb.psel && !apb.penable) begin
                        state_q   <= ACCESS;
                        pready_q  <= apb.pwrite;
                        pslverr_q <= apb.pwrite && acc_err;
                    end
                end
                ACCESS: begin
                    if (!apb.psel || pready_q) begin
                        state_q   <= IDLE;
                        pready_q  <= 1'b0;
                        pslverr_q <= 1'b0;
                    end else begin
                        prdata_q  <= rdata;
                        pslverr_q <= acc_err;
                        pready_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (p_reset) begin
            dir_q      <= '0;
            dout_q     <= '0;
            int_en_q   <= '0;
            int_pol_q  <= '0;
            int_stat_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            if (commit && ofs == GPIO_DIR_OFS)     dir_q     <= wdata;
            if (commit && ofs == GPIO_DOUT_OFS)    dout_q    <= wdata;
            if (commit && ofs == GPIO_INT_EN_OFS)  int_en_q  <= wdata;
            if (commit && ofs == GPIO_INT_POL_OFS) int_pol_q <= wdata;
            // A new edge on a bit being cleared keeps the bit set.
            int_stat_q <= (int_stat_q & ~w1c_mask) | edge_evt;
            irq_q      <= |(int_stat_q & int_en_q);
        end
    end

    assign apb.prdata    = prdata_q;
    assign apb.pready    = pready_q;
    assign apb.pslverr   = pslverr_q;
    assign n_gpio_pin_oe = ~dir_q;
    assign gpio_pin_out  = dout_q;
    assign gpio_irq      = irq_q;

endmodule

// File: tb/tb_gpio_apb_ctrl.sv
// Self-checking bench for gpio_apb_ctrl: directed scenarios plus randomized
// register/pin traffic against a register-level reference model.
module tb_gpio_apb_ctrl;

    localparam int W = 16;

    logic         pclk = 1'b0;
    logic         p_reset;
    logic [W-1:0] n_oe;
    logic [W-1:0] pout;
    logic [W-1:0] pin;
    logic         irq;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [W-1:0] m_dir, m_dout, m_en, m_pol, m_stat, m_pins;

    gpio_apb_ctrl_if #(.ADDR_WIDTH(8)) apb ();

    gpio_apb_ctrl #(
        .GPIO_DATA_WIDTH (W),
        .ADDR_WIDTH      (8)
    ) dut (
        .pclk          (pclk),
        .p_reset       (p_reset),
        .apb           (apb),
        .n_gpio_pin_oe (n_oe),
        .gpio_pin_out  (pout),
        .gpio_pin_in   (pin),
        .gpio_irq      (irq)
    );

    always #5 pclk = ~pclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                            output logic [31:0] rd, output logic err, output int waits);
        @(posedge pclk);
        #1;
        apb.psel    = 1'b1;
        apb.penable = 1'b0;
        apb.pwrite  = wr;
        apb.paddr   = addr;
        apb.pwdata  = data;
        @(posedge pclk);
        #1;
        apb.penable = 1'b1;
        waits = 0;
        while (apb.pready !== 1'b1 && waits < 8) begin
            @(posedge pclk);
            #1;
            waits++;
        end
        if (apb.pready !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL apb_timeout addr=%h: pready=%b required 1", addr, apb.pready);
        end
        rd  = apb.prdata;
        err = apb.pslverr;
        @(posedge pclk);
        #1;
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b0;
    endtask

    task automatic model_reset();
        m_dir  = '0;
        m_dout = '0;
        m_en   = '0;
        m_pol  = '0;
        m_stat = '0;
    endtask

    task automatic test_reset();
        pin         = '0;
        m_pins      = '0;
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b0;
        apb.paddr   = '0;
        apb.pwdata  = '0;
        p_reset     = 1'b1;
        idle(3);
        n_cmp++;
        if (n_oe !== 16'hFFFF) begin
            n_fail++; $display("FAIL reset_oe: n_gpio_pin_oe=%h required FFFF", n_oe);
        end
        n_cmp++;
        if (pout !== 16'h0000) begin
            n_fail++; $display("FAIL reset_out: gpio_pin_out=%h required 0000", pout);
        end
        n_cmp++;
        if ({irq, apb.pready, apb.pslverr} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctl: irq/pready/pslverr=%b required 000",
                               {irq, apb.pready, apb.pslverr});
        end
        n_cmp++;
        if (apb.prdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_prdata: prdata=%h required 0", apb.prdata);
        end
        p_reset = 1'b0;
        model_reset();
    endtask

    task automatic test_dir_dout();
        logic [31:0] rd;
        logic        err;
        int          waits;
        apb_xfer(1'b1, 8'h00, 32'h0000_00FF, rd, err, waits);
        m_dir = 16'h00FF;
        n_cmp++;
        if (waits !== 0 || err !== 1'b0) begin
            n_fail++; $display("FAIL wr_dir_resp: waits=%0d err=%b required 0/0", waits, err);
        end
        n_cmp++;
        if (n_oe !== 16'hFF00) begin
            n_fail++; $display("FAIL wr_dir_oe: n_gpio_pin_oe=%h required FF00", n_oe);
        end
        apb_xfer(1'b1, 8'h04, 32'h0000_A5A5, rd, err, waits);
        m_dout = 16'hA5A5;
        n_cmp++;
        if (waits !== 0 || pout !== 16'hA5A5) begin
            n_fail++; $display("FAIL wr_dout: waits=%0d out=%h required 0/A5A5", waits, pout);
        end
        apb_xfer(1'b0, 8'h04, 32'h0, rd, err, waits);
        n_cmp++;
        if (waits !== 1 || rd !== 32'h0000_A5A5 || err !== 1'b0) begin
            n_fail++; $display("FAIL rd_dout: waits=%0d data=%h err=%b required 1/0000A5A5/0",
                               waits, rd, err);
        end
    endtask

    task automatic test_irq_edge();
        logic [31:0] rd;
        logic        err;
        int          waits;
        apb_xfer(1'b1, 8'h0C, 32'h8, rd, err, waits);
        apb_xfer(1'b1, 8'h10, 32'h8, rd, err, waits);
        m_en  = 16'h8;
        m_pol = 16'h8;
        // Pin rises right after the setup edge, so DIN is sampled at N+2 (too early).
        fork
            apb_xfer(1'b0, 8'h08, 32'h0, rd, err, waits);
            begin
                @(posedge pclk);
                #1;
                pin    = 16'h0008;
                m_pins = 16'h0008;
            end
        join
        n_cmp++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL din_latency_n2: DIN=%h required 0", rd);
        end
        n_cmp++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL irq_n3: gpio_irq=%b required 0", irq);
        end
        idle(1);
        m_stat = 16'h8;
        n_cmp++;
        if (irq !== 1'b1) begin
            n_fail++; $display("FAIL irq_n4: gpio_irq=%b required 1", irq);
        end
        apb_xfer(1'b0, 8'h08, 32'h0, rd, err, waits);
        n_cmp++;
        if (rd !== 32'h8) begin
            n_fail++; $display("FAIL din_bit3: DIN=%h required 8", rd);
        end
        apb_xfer(1'b0, 8'h14, 32'h0, rd, err, waits);
        n_cmp++;
        if (rd !== 32'h8) begin
            n_fail++; $display("FAIL stat_rise: INT_STAT=%h required 8", rd);
        end
        apb_xfer(1'b1, 8'h14, 32'h8, rd, err, waits);
        m_stat = '0;
        n_cmp++;
        if (irq !== 1'b1) begin
            n_fail++; $display("FAIL irq_clr_commit: gpio_irq=%b required 1", irq);
        end
        idle(1);
        n_cmp++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL irq_clr_next: gpio_irq=%b required 0", irq);
        end
        pin    = 16'h0000;
        m_pins = 16'h0000;
        idle(6);
        apb_xfer(1'b0, 8'h14, 32'h0, rd, err, waits);
        n_cmp++;
        if (rd !== 32'h0 || irq !== 1'b0) begin
            n_fail++; $display("FAIL stat_fall_ignored: INT_STAT=%h irq=%b required 0/0", rd, irq);
        end
    endtask

    task automatic test_w1c_race();
        logic [31:0] rd;
        logic        err;
        int          waits;
        pin = 16'h0008;
        idle(6);
        pin = 16'h0000;
        idle(6);
        m_stat = 16'h8;
        n_cmp++;
        if (irq !== 1'b1) begin
            n_fail++; $display("FAIL race_pre_irq: gpio_irq=%b required 1", irq);
        end
        // Rise at edge N lands in INT_STAT at N+3, the clearing write's commit edge.
        @(posedge pclk);
        #1;
        pin    = 16'h0008;
        m_pins = 16'h0008;
        apb_xfer(1'b1, 8'h14, 32'h8, rd, err, waits);
        idle(1);
        n_cmp++;
        if (irq !== 1'b1) begin
            n_fail++; $display("FAIL race_irq: gpio_irq=%b required 1", irq);
        end
        apb_xfer(1'b0, 8'h14, 32'h0, rd, err, waits);
        n_cmp++;
        if (rd !== 32'h8) begin
            n_fail++; $display("FAIL race_stat: INT_STAT=%h required 8", rd);
        end
        apb_xfer(1'b1, 8'h14, 32'h8, rd, err, waits);
        m_stat = '0;
        n_cmp++;
        if (irq !== 1'b1) begin
            n_fail++; $display("FAIL race_clr_commit: gpio_irq=%b required 1", irq);
        end
        idle(1);
        n_cmp++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL race_clr_next: gpio_irq=%b required 0", irq);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic        err;
        int          waits;
        apb_xfer(1'b0, 8'h04, 32'h0, rd, err, waits);
        apb_xfer(1'b0, 8'h1C, 32'h0, rd, err, waits);
        n_cmp++;
        if (err !== 1'b1 || rd !== 32'h0 || waits !== 1) begin
            n_fail++; $display("FAIL err_rd_1c: err=%b data=%h waits=%0d required 1/0/1",
                               err, rd, waits);
        end
        apb_xfer(1'b1, 8'h08, 32'hFFFF_FFFF, rd, err, waits);
        n_cmp++;
        if (err !== 1'b1 || waits !== 0) begin
            n_fail++; $display("FAIL err_wr_din: err=%b waits=%0d required 1/0", err, waits);
        end
        apb_xfer(1'b0, 8'h08, 32'h0, rd, err, waits);
        n_cmp++;
        if (rd !== {16'h0, m_pins} || err !== 1'b0) begin
            n_fail++; $display("FAIL din_after_err: DIN=%h err=%b required %h/0", rd, err, m_pins);
        end
        apb_xfer(1'b0, 8'h02, 32'h0, rd, err, waits);
        n_cmp++;
        if (err !== 1'b1 || rd !== 32'h0) begin
            n_fail++; $display("FAIL err_rd_misalign: err=%b data=%h required 1/0", err, rd);
        end
        apb_xfer(1'b1, 8'h02, 32'hFFFF_FFFF, rd, err, waits);
        n_cmp++;
        if (err !== 1'b1 || n_oe !== ~m_dir) begin
            n_fail++; $display("FAIL err_wr_misalign: err=%b oe=%h required 1/%h", err, n_oe, ~m_dir);
        end
        apb_xfer(1'b1, 8'h18, 32'hFFFF_FFFF, rd, err, waits);
        n_cmp++;
        if (err !== 1'b1) begin
            n_fail++; $display("FAIL err_wr_pend: err=%b required 1", err);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic        err;
        int          waits;
        @(posedge pclk);
        #1;
        apb.psel    = 1'b1;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b0;
        apb.paddr   = 8'h04;
        @(posedge pclk);
        #1;
        apb.penable = 1'b1;
        n_cmp++;
        if (apb.pready !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_wait: pready=%b required 0", apb.pready);
        end
        p_reset = 1'b1;
        @(posedge pclk);
        #1;
        p_reset     = 1'b0;
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        model_reset();
        n_cmp++;
        if (apb.pready !== 1'b0 || n_oe !== 16'hFFFF) begin
            n_fail++; $display("FAIL rstmid_pready: pready=%b oe=%h required 0/FFFF",
                               apb.pready, n_oe);
        end
        idle(1);
        n_cmp++;
        if (apb.pready !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_nopulse: pready=%b required 0", apb.pready);
        end
        apb_xfer(1'b0, 8'h04, 32'h0, rd, err, waits);
        n_cmp++;
        if (waits !== 1 || rd !== 32'h0 || err !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_next_rd: waits=%0d data=%h err=%b required 1/0/0",
                               waits, rd, err);
        end
        idle(4);
    endtask

    task automatic test_random();
        logic [31:0]  rd;
        logic         err;
        int           waits;
        logic [31:0]  d;
        logic [W-1:0] newp;
        logic [W-1:0] exp;
        int           op;
        int           r;
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 6);
            d  = $urandom;
            case (op)
                0, 1, 2, 3: begin
                    case (op)
                        0: begin apb_xfer(1'b1, 8'h00, d, rd, err, waits); m_dir  = d[W-1:0]; end
                        1: begin apb_xfer(1'b1, 8'h04, d, rd, err, waits); m_dout = d[W-1:0]; end
                        2: begin apb_xfer(1'b1, 8'h0C, d, rd, err, waits); m_en   = d[W-1:0]; end
                        default: begin
                            apb_xfer(1'b1, 8'h10, d, rd, err, waits);
                            m_pol = d[W-1:0];
                        end
                    endcase
                    n_cmp++;
                    if (err !== 1'b0 || waits !== 0) begin
                        n_fail++; $display("FAIL rnd_wr[%0d]: err=%b waits=%0d required 0/0",
                                           i, err, waits);
                    end
                end
                4: begin
                    apb_xfer(1'b1, 8'h14, d, rd, err, waits);
                    m_stat = m_stat & ~d[W-1:0];
                end
                5: begin
                    newp = d[W-1:0];
                    @(posedge pclk);
                    #1;
                    pin = newp;
                    idle(5);
                    m_stat = m_stat | (m_pol & newp & ~m_pins) | (~m_pol & ~newp & m_pins);
                    m_pins = newp;
                end
                default: begin
                    r = $urandom_range(0, 6);
                    case (r)
                        0: exp = m_dir;
                        1: exp = m_dout;
                        2: exp = m_pins;
                        3: exp = m_en;
                        4: exp = m_pol;
                        5: exp = m_stat;
                        default: exp = m_stat & m_en;
                    endcase
                    apb_xfer(1'b0, 8'(r * 4), 32'h0, rd, err, waits);
                    n_cmp++;
                    if (rd !== {16'h0, exp} || err !== 1'b0 || waits !== 1) begin
                        n_fail++; $display("FAIL rnd_rd[%0d] ofs=%0h: data=%h err=%b waits=%0d required %h/0/1",
                                           i, r * 4, rd, err, waits, exp);
                    end
                end
            endcase
            idle(1);
            n_cmp++;
            if (n_oe !== ~m_dir || pout !== m_dout || irq !== |(m_stat & m_en)) begin
                n_fail++; $display("FAIL rnd_pins[%0d]: oe=%h out=%h irq=%b required %h/%h/%b",
                                   i, n_oe, pout, irq, ~m_dir, m_dout, |(m_stat & m_en));
            end
        end
    endtask

    initial begin
        test_reset();
        test_dir_dout();
        test_irq_edge();
        test_w1c_race();
        test_errors();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
